// File: rtl/rv_mul_dp_if.sv
// Control-plane MUL micro-step bus between the sequencer and rv_mul_dp.
// Operands, step selects and the registered multiply results.
interface rv_mul_dp_if;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [1:0]  Ma_sel;
  logic [1:0]  Mb_sel;
  logic [4:0]  Mshift_val;
  logic        Mupd_reg;
  logic        Mclr_reg;
  logic [31:0] mul_res;
  logic        mul_done;
  logic        mul_err;
  logic [3:0]  pair_cnt;

  modport master (
    output rs1_val, rs2_val,
    output Ma_sel, Mb_sel, Mshift_val,
    output Mupd_reg, Mclr_reg,
    input  mul_res, mul_done,
    input  mul_err, pair_cnt
  );

  modport slave (
    input  rs1_val, rs2_val,
    input  Ma_sel, Mb_sel, Mshift_val,
    input  Mupd_reg, Mclr_reg,
    output mul_res, mul_done,
    output mul_err, pair_cnt
  );
endinterface

// File: rtl/rv_mul_dp.sv
// Byte-serial multiply datapath: accumulates ten 8x8 partial products
// into the low 32 bits of rs1*rs2 and tracks step coverage/errors.
module rv_mul_dp (
  input  logic           clk,
  input  logic           rst,
  rv_mul_dp_if.slave     bus
);

  logic [31:0] r_opA;
  logic [31:0] r_opB;
  logic [31:0] r_acc;
  logic [9:0]  r_cov;
  logic [3:0]  r_cnt;
  logic        r_err;
  logic        r_done;

  logic [7:0]  w_a_byte;
  logic [7:0]  w_b_byte;
  logic [15:0] w_prod;
  logic [31:0] w_addend;
  logic [2:0]  w_sum;
  logic        w_valid;
  logic [3:0]  w_idx;
  logic [9:0]  w_bit;
  logic        w_dup;
  logic        w_new;
  logic        w_bad;
  logic [9:0]  w_cov_nx;

  always_comb begin
    w_a_byte = r_opA[{bus.Ma_sel, 3'b000} +: 8];
    w_b_byte = r_opB[{bus.Mb_sel, 3'b000} +: 8];
    w_prod   = {8'b0, w_a_byte} * {8'b0, w_b_byte};
    w_addend = {16'b0, w_prod} << bus.Mshift_val;
    w_sum    = {1'b0, bus.Ma_sel} + {1'b0, bus.Mb_sel};
    w_valid  = (w_sum <= 3'd3);
  end

  // Coverage bit layout: a=0 -> 0..3, a=1 -> 4..6, a=2 -> 7..8, a=3 -> 9
  always_comb begin
    w_idx = 4'd0;
    case (bus.Ma_sel)
      2'd0:    w_idx = {2'b00, bus.Mb_sel};
      2'd1:    w_idx = 4'd4 + {2'b00, bus.Mb_sel};
      2'd2:    w_idx = 4'd7 + {2'b00, bus.Mb_sel};
      default: w_idx = 4'd9;
    endcase
  end

  always_comb begin
    w_bit    = w_valid ? (10'b1 << w_idx) : 10'b0;
    w_dup    = |(r_cov & w_bit);
    w_new    = w_valid & ~w_dup;
    w_bad    = ~w_valid | w_dup |
               ({1'b0, bus.Mshift_val} != {w_sum, 3'b000});
    w_cov_nx = r_cov | (w_new ? w_bit : 10'b0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_opA  <= '0;
      r_opB  <= '0;
      r_acc  <= '0;
      r_cov  <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_done <= 1'b0;
    end else if (bus.Mclr_reg) begin
      r_opA  <= bus.rs1_val;
      r_opB  <= bus.rs2_val;
      r_acc  <= '0;
      r_cov  <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_done <= 1'b0;
    end else if (bus.Mupd_reg) begin
      r_acc  <= r_acc + w_addend;
      r_cov  <= w_cov_nx;
      r_cnt  <= r_cnt + {3'b000, w_new};
      r_err  <= r_err | w_bad;
      r_done <= &w_cov_nx;
    end
  end

  assign bus.mul_res  = r_acc;
  assign bus.mul_done = r_done;
  assign bus.mul_err  = r_err;
  assign bus.pair_cnt = r_cnt;

endmodule
